string_pattern_tx: RTL

Serial pattern transmitter, the source end of the serial bit-stream protocol consumed by the team's 1101 sequence detector. It loads a PAT_W-bit pattern and sends it MSB-first on a 1-bit line, one bit per clock. The pattern is sent repeat_n times, with an optional idle gap between repetitions. The block drives detector benches and on-chip self-test, with a start/busy/done handshake toward the controlling logic.

---
 rtl/string_fsm_pkg.sv | 18 +
 rtl/pattern_piso.sv | 59 +++++
 rtl/string_pattern_tx.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/string_fsm_pkg.sv
// Shared definitions for the serial pattern transmitter and the 1101 detector:
// FSM state encoding, the reference pattern and default widths.
package string_fsm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [3:0] PAT_1101 = 4'b1101;

  localparam int DEF_PAT_W = 4;
  localparam int DEF_CNT_W = 8;
  localparam int DEF_GAP_W = 4;

endpackage

// File: rtl/pattern_piso.sv
// Parallel-load, MSB-first shift register. sh_q[PAT_W-1] is the bit currently on
// the line; next_bit previews what the line will carry after this edge.
module pattern_piso #(
  parameter int              PAT_W       = 4,
  parameter logic [PAT_W-1:0] PAT_DEFAULT = '0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic             reload,
  input  logic             shift,
  input  logic [PAT_W-1:0] pat_in,
  output logic             next_bit,
  output logic             last_bit
);

  localparam int CW = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(PAT_W - 1);

  logic [PAT_W-1:0] pat_q, pat_d;
  logic [PAT_W-1:0] sh_q, sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_comb begin
    pat_d    = pat_q;
    sh_d     = sh_q;
    cnt_d    = cnt_q;
    next_bit = sh_q[PAT_W-1];
    if (load) begin
      pat_d    = pat_in;
      sh_d     = pat_in;
      cnt_d    = '0;
      next_bit = pat_in[PAT_W-1];
    end else if (reload) begin
      sh_d     = pat_q;
      cnt_d    = '0;
      next_bit = pat_q[PAT_W-1];
    end else if (shift) begin
      sh_d     = {sh_q[PAT_W-2:0], 1'b0};
      cnt_d    = cnt_q + CW'(1);
      next_bit = sh_q[PAT_W-2];
    end
  end

  assign last_bit = (cnt_q == LAST_IDX);

  always_ff @(posedge clk) begin
    if (clr) begin
      pat_q <= PAT_DEFAULT;
      sh_q  <= '0;
      cnt_q <= '0;
    end else begin
      pat_q <= pat_d;
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/string_pattern_tx.sv
// Serial pattern transmitter: sends a captured pattern MSB-first repeat_n times
// with an optional idle gap between repetitions, under a start/busy/done handshake.
module string_pattern_tx
  import string_fsm_pkg::*;
#(
  parameter int               PAT_W       = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PAT_DEFAULT = PAT_1101,
  parameter int               CNT_W       = DEF_CNT_W,
  parameter int               GAP_W       = DEF_GAP_W
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_n,
  input  logic [GAP_W-1:0] gap,
  input  logic             idle_level,
  output logic             x,
  output logic             x_valid,
  output logic             frame_start,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic [GAP_W-1:0] gap_len_q, gap_len_d;
  logic [GAP_W-1:0] gcnt_q, gcnt_d;
  logic [CNT_W-1:0] rem;

  logic x_q, x_d;
  logic x_valid_q, x_valid_d;
  logic frame_start_q, frame_start_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  logic load, reload, shift;
  logic next_bit, last_bit;

  pattern_piso #(
    .PAT_W      (PAT_W),
    .PAT_DEFAULT(PAT_DEFAULT)
  ) u_piso (
    .clk     (clk),
    .clr     (clr),
    .load    (load),
    .reload  (reload),
    .shift   (shift),
    .pat_in  (pattern),
    .next_bit(next_bit),
    .last_bit(last_bit)
  );

  always_comb begin
    state_d   = state_q;
    rep_d     = rep_q;
    gap_len_d = gap_len_q;
    gcnt_d    = gcnt_q;
    rem       = rep_q - CNT_W'(1);
    load      = 1'b0;
    reload    = 1'b0;
    shift     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          rep_d     = repeat_n;
          gap_len_d = gap;
          state_d   = (repeat_n == '0) ? DONE : SEND;
        end
      end
      SEND: begin
        if (last_bit) begin
          rep_d = rem;
          if (rem == '0) begin
            state_d = DONE;
          end else if (gap_len_q != '0) begin
            state_d = GAP;
            gcnt_d  = gap_len_q;
          end else begin
            reload = 1'b1;
          end
        end else begin
          shift = 1'b1;
        end
      end
      GAP: begin
        // gcnt_q holds the gap cycles remaining including the current one
        if (gcnt_q <= GAP_W'(1)) begin
          gcnt_d  = '0;
          reload  = 1'b1;
          state_d = SEND;
        end else begin
          gcnt_d = gcnt_q - GAP_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are computed from the next state so they register alongside it
    x_valid_d     = (state_d == SEND);
    frame_start_d = (state_d == SEND) && (load || reload);
    busy_d        = (state_d == SEND) || (state_d == GAP);
    done_d        = (state_d == DONE);
    x_d           = x_valid_d ? next_bit : idle_level;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q       <= IDLE;
      rep_q         <= '0;
      gap_len_q     <= '0;
      gcnt_q        <= '0;
      x_q           <= 1'b0;
      x_valid_q     <= 1'b0;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      rep_q         <= rep_d;
      gap_len_q     <= gap_len_d;
      gcnt_q        <= gcnt_d;
      x_q           <= x_d;
      x_valid_q     <= x_valid_d;
      frame_start_q <= frame_start_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign x           = x_q;
  assign x_valid     = x_valid_q;
  assign frame_start = frame_start_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
